// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer and synchronous flush.
// Optional stall/flush performance counters are enabled with PIPE_STAGE_PERF_EN.

module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  // state    | meaning
  // ST_EMPTY | no entry held, outputs invalid
  // ST_ONE   | main entry M valid, skid S free
  // ST_FULL  | M and S both valid, upstream stalled
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;
  logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
  logic                accept;
  logic                retire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = m_data_q;
  assign out_ctrl  = out_valid ? m_ctrl_q : '0;
  assign in_ready  = in_ready_q;

  assign accept = in_valid & in_ready_q;
  assign retire = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (flush) begin
      // Payloads are left stale; only control is scrubbed so a killed entry cannot write back.
      state_d  = ST_EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d  = ST_ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && retire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (accept) begin
            state_d  = ST_FULL;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end else if (retire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (retire) begin
            state_d  = ST_ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Registered ready looks only at our own next occupancy, never at out_ready.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      m_data_q   <= '0;
      m_ctrl_q   <= '0;
      s_data_q   <= '0;
      s_ctrl_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      m_ctrl_q   <= m_ctrl_d;
      s_data_q   <= s_data_d;
      s_ctrl_q   <= s_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; perf counter tests run when
// PIPE_STAGE_PERF_EN is defined.

module tb_pipe_stage_reg;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_ctrl !== '0)    begin errors++; $display("FAIL rst_out_ctrl: got %h expected 0", out_ctrl); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    @(negedge clk);
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5;
    in_ctrl   = 9'h1F3;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_pre: got %b expected 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid_early: got %b expected 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5) begin
      errors++; $display("FAIL first_out_data: got %h expected ..66A5", out_data);
    end
    checks++; if (out_ctrl !== 9'h1F3) begin errors++; $display("FAIL first_out_ctrl: got %h expected 1f3", out_ctrl); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_drain: got %b expected 0", out_valid); end
    checks++; if (out_ctrl !== '0)    begin errors++; $display("FAIL first_drain_ctrl: got %h expected 0", out_ctrl); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DATA_W'(i);
      in_ctrl = CTRL_W'(i + 16);
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_data !== DATA_W'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, out_data, i); end
      checks++; if (out_ctrl !== CTRL_W'(i + 16)) begin errors++; $display("FAIL stream_ctrl[%0d]: got %0h expected %0h", i, out_ctrl, i + 16); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'd1;
    in_ctrl   = 9'h001;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_one_ready: got %b expected 1", in_ready); end
    in_data = 128'd2;
    in_ctrl = 9'h002;
    step();
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    checks++; if (out_data !== 128'd1) begin errors++; $display("FAIL bp_full_head: got %0h expected 1", out_data); end
    in_data = 128'd3;
    in_ctrl = 9'h003;
    step();
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_hold_ready: got %b expected 0", in_ready); end
    checks++; if (out_data !== 128'd1) begin errors++; $display("FAIL bp_hold_head: got %0h expected 1", out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 128'd2) begin errors++; $display("FAIL bp_out2: got %0h expected 2", out_data); end
    checks++; if (out_ctrl !== 9'h002) begin errors++; $display("FAIL bp_ctrl2: got %0h expected 2", out_ctrl); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_reopen: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 128'd3) begin errors++; $display("FAIL bp_out3: got %0h expected 3", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid3: got %b expected 1", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'd4;
    in_ctrl   = 9'h044;
    step();
    in_data = 128'd5;
    in_ctrl = 9'h055;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_full_ready: got %b expected 0", in_ready); end
    flush   = 1'b1;
    in_data = 128'd6;
    in_ctrl = 9'h066;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b expected 0", out_valid); end
    checks++; if (out_ctrl !== '0)    begin errors++; $display("FAIL fl_ctrl: got %h expected 0", out_ctrl); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL fl_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped6: got %b expected 0", out_valid); end
    in_valid  = 1'b1;
    in_data   = 128'd7;
    in_ctrl   = 9'h077;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 128'd7) begin errors++; $display("FAIL fl_out7: got %0h expected 7", out_data); end
    checks++; if (out_ctrl !== 9'h077) begin errors++; $display("FAIL fl_ctrl7: got %0h expected 77", out_ctrl); end
    step();
    // Flush in ONE while in_ready=1: the offered entry must still be dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'd9;
    in_ctrl   = 9'h099;
    step();
    flush   = 1'b1;
    in_data = 128'd10;
    in_ctrl = 9'h0AA;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_one_valid: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_one_dropped: got %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'd11;
    in_ctrl   = 9'h0BB;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL ar_ready: got %b expected 0", in_ready); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL ar_data: got %h expected 0", out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL ar_release_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_release_valid: got %b expected 0", out_valid); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    checks++; if (perf_stall_cnt !== 4'd0) begin errors++; $display("FAIL pf_stall_rst: got %0d expected 0", perf_stall_cnt); end
    checks++; if (perf_flush_cnt !== 4'd0) begin errors++; $display("FAIL pf_flush_rst: got %0d expected 0", perf_flush_cnt); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'd12;
    in_ctrl   = 9'h0CC;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (perf_stall_cnt !== 4'd3) begin errors++; $display("FAIL pf_stall3: got %0d expected 3", perf_stall_cnt); end
    repeat (17) step();
    checks++; if (perf_stall_cnt !== 4'd15) begin errors++; $display("FAIL pf_stall_sat: got %0d expected 15", perf_stall_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (perf_flush_cnt !== 4'd1) begin errors++; $display("FAIL pf_flush1: got %0d expected 1", perf_flush_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (perf_flush_cnt !== 4'd1) begin errors++; $display("FAIL pf_flush_empty: got %0d expected 1", perf_flush_cnt); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (perf_flush_cnt !== 4'd2) begin errors++; $display("FAIL pf_flush2: got %0d expected 2", perf_flush_cnt); end
    checks++; if (perf_stall_cnt !== 4'd15) begin errors++; $display("FAIL pf_stall_hold: got %0d expected 15", perf_stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    chk("final_idle_valid", {127'd0, out_valid}, 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
